// File: rtl/usb_capture_packer.sv
// Packs the captured byte stream into BYTES-wide little-endian words with last/byte-count tags.
// Optional idle auto-flush is compiled in when PACKER_TIMEOUT_EN is defined.
module usb_capture_packer #(
    parameter int          BYTES     = 2,
    parameter int          TIMEOUT_W = 16,
    parameter logic [7:0]  PAD       = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [7:0]           in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ack_o,
    input  logic                 flush_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    output logic [8*BYTES-1:0]   out_data_o,
    output logic [3:0]           out_nbytes_o,
    output logic                 out_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam int DW = 8 * BYTES;

    typedef enum logic {StFill, StFlush} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_cnt;
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   r_out_data;
    logic [3:0]      r_out_nbytes;
    logic            r_out_last;
    logic            r_out_valid;

    logic            w_slot;
    logic            w_ack;
    logic            w_flush_pend;
    logic            w_flush_req;
    logic            w_flush_exec;
    logic            w_word_done;
    logic            w_timeout;
    logic [DW-1:0]   w_acc_next;
    logic [DW-1:0]   w_pad_word;

    assign w_slot      = !r_out_valid || out_ready_i;
    assign w_ack       = in_valid_i && !w_flush_pend && !flush_i &&
                         ((r_cnt < 4'(BYTES - 1)) || w_slot);
    assign w_word_done = w_ack && (r_cnt == 4'(BYTES - 1));
    assign w_flush_req = (r_state == StFill) && (flush_i || w_timeout);

`ifdef PACKER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_idle;

    assign w_timeout = (cfg_timeout_i != '0) && (r_idle == cfg_timeout_i) && (r_state == StFill);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_idle <= '0;
        end else if ((r_state == StFlush) || (r_cnt == 4'd0) || w_ack || flush_i || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^cfg_timeout_i;
    assign w_timeout    = 1'b0;
`endif

    // Current byte merged into its lane; the full word is taken from here directly.
    always_comb begin
        w_acc_next = r_acc;
        w_pad_word = r_acc;
        for (int i = 0; i < BYTES; i++) begin
            if (r_cnt == 4'(i)) begin
                w_acc_next[i*8 +: 8] = in_data_i;
            end
            if (4'(i) >= r_cnt) begin
                w_pad_word[i*8 +: 8] = PAD;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFill:  if (w_flush_req) w_state_next = StFlush;
            StFlush: if (w_slot)      w_state_next = StFill;
            default: w_state_next = StFill;
        endcase
    end

    always_comb begin
        w_flush_pend = (r_state == StFlush);
        w_flush_exec = w_flush_pend && w_slot;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt        <= 4'd0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_nbytes <= 4'd0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_ack) begin
                r_acc <= w_acc_next;
                r_cnt <= w_word_done ? 4'd0 : r_cnt + 4'd1;
            end
            if (w_word_done) begin
                r_out_data   <= w_acc_next;
                r_out_nbytes <= 4'(BYTES);
                r_out_last   <= 1'b0;
                r_out_valid  <= 1'b1;
            end else if (w_flush_exec) begin
                if (r_cnt != 4'd0) begin
                    r_out_data   <= w_pad_word;
                    r_out_nbytes <= r_cnt;
                    r_out_last   <= 1'b1;
                    r_out_valid  <= 1'b1;
                    r_cnt        <= 4'd0;
                end else if (r_out_valid && !out_ready_i) begin
                    r_out_last <= 1'b1;
                end else begin
                    // Empty packet marker so the host issues a zero-length packet.
                    r_out_data   <= '0;
                    r_out_nbytes <= 4'd0;
                    r_out_last   <= 1'b1;
                    r_out_valid  <= 1'b1;
                end
            end else if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ack_o     = w_ack;
    assign out_data_o   = r_out_data;
    assign out_nbytes_o = r_out_nbytes;
    assign out_last_o   = r_out_last;
    assign out_valid_o  = r_out_valid;

endmodule

// File: tb/tb_usb_capture_packer.sv
// Directed bench for usb_capture_packer: BYTES=2 vector table plus BYTES=4 and reset/timeout sequences.
module tb_usb_capture_packer;

    logic        clk;
    logic        rst_n;

    logic [7:0]  in_data2, in_data4;
    logic        in_valid2, in_valid4;
    logic        in_ack2, in_ack4;
    logic        flush2, flush4;
    logic [15:0] cfg2, cfg4;
    logic [15:0] out_data2;
    logic [31:0] out_data4;
    logic [3:0]  out_nb2, out_nb4;
    logic        out_last2, out_last4;
    logic        out_valid2, out_valid4;
    logic        out_ready2, out_ready4;

    int n_checks = 0;
    int n_fail   = 0;

    usb_capture_packer #(.BYTES(2), .TIMEOUT_W(16), .PAD(8'h00)) u_dut2 (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .in_data_i    (in_data2),
        .in_valid_i   (in_valid2),
        .in_ack_o     (in_ack2),
        .flush_i      (flush2),
        .cfg_timeout_i(cfg2),
        .out_data_o   (out_data2),
        .out_nbytes_o (out_nb2),
        .out_last_o   (out_last2),
        .out_valid_o  (out_valid2),
        .out_ready_i  (out_ready2)
    );

    usb_capture_packer #(.BYTES(4), .TIMEOUT_W(16), .PAD(8'h00)) u_dut4 (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .in_data_i    (in_data4),
        .in_valid_i   (in_valid4),
        .in_ack_o     (in_ack4),
        .flush_i      (flush4),
        .cfg_timeout_i(cfg4),
        .out_data_o   (out_data4),
        .out_nbytes_o (out_nb4),
        .out_last_o   (out_last4),
        .out_valid_o  (out_valid4),
        .out_ready_i  (out_ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        rdy;
        logic        e_ack;
        logic        e_ov;
        logic [15:0] e_data;
        logic [3:0]  e_nb;
        logic        e_last;
    } vec_t;

    vec_t vecs [27];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive for one cycle; returns 4ns after the edge so outputs can be sampled.
    task automatic drive2(input logic v, input logic [7:0] d, input logic f, input logic rdy);
        @(posedge clk);
        #1;
        in_valid2  = v;
        in_data2   = d;
        flush2     = f;
        out_ready2 = rdy;
        #3;
    endtask

    task automatic drive4(input logic v, input logic [7:0] d, input logic f);
        @(posedge clk);
        #1;
        in_valid4 = v;
        in_data4  = d;
        flush4    = f;
        #3;
    endtask

    initial begin
        int cyc;
        in_data2 = 8'h00; in_valid2 = 1'b0; flush2 = 1'b0; cfg2 = 16'd0; out_ready2 = 1'b1;
        in_data4 = 8'h00; in_valid4 = 1'b0; flush4 = 1'b0; cfg4 = 16'd0; out_ready4 = 1'b1;
        rst_n = 1'b0;

        //          v  d      f  rdy  ack ov  data      nb    last
        vecs[0]  = '{1, 8'h11, 0, 1,  1,  0,  16'h0000, 4'd0, 0};
        vecs[1]  = '{1, 8'h22, 0, 1,  1,  0,  16'h0000, 4'd0, 0};
        vecs[2]  = '{1, 8'h33, 0, 1,  1,  1,  16'h2211, 4'd2, 0};
        vecs[3]  = '{1, 8'h44, 0, 1,  1,  0,  16'h0000, 4'd0, 0};
        vecs[4]  = '{0, 8'h00, 0, 0,  0,  1,  16'h4433, 4'd2, 0};
        vecs[5]  = '{1, 8'h55, 0, 0,  1,  1,  16'h4433, 4'd2, 0};
        vecs[6]  = '{1, 8'h66, 0, 0,  0,  1,  16'h4433, 4'd2, 0};
        vecs[7]  = '{1, 8'h66, 0, 0,  0,  1,  16'h4433, 4'd2, 0};
        vecs[8]  = '{1, 8'h66, 0, 1,  1,  1,  16'h4433, 4'd2, 0};
        vecs[9]  = '{0, 8'h00, 0, 0,  0,  1,  16'h6655, 4'd2, 0};
        vecs[10] = '{0, 8'h00, 0, 1,  0,  1,  16'h6655, 4'd2, 0};
        vecs[11] = '{0, 8'h00, 1, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[12] = '{0, 8'h00, 1, 0,  0,  0,  16'h0000, 4'd0, 0};
        vecs[13] = '{0, 8'h00, 0, 0,  0,  1,  16'h0000, 4'd0, 1};
        vecs[14] = '{0, 8'h00, 0, 1,  0,  1,  16'h0000, 4'd0, 1};
        vecs[15] = '{0, 8'h00, 0, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[16] = '{1, 8'h77, 1, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[17] = '{1, 8'h77, 0, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[18] = '{1, 8'h77, 0, 1,  1,  1,  16'h0000, 4'd0, 1};
        vecs[19] = '{1, 8'h88, 0, 1,  1,  0,  16'h0000, 4'd0, 0};
        vecs[20] = '{0, 8'h00, 0, 1,  0,  1,  16'h8877, 4'd2, 0};
        vecs[21] = '{0, 8'h00, 0, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[22] = '{1, 8'h99, 0, 1,  1,  0,  16'h0000, 4'd0, 0};
        vecs[23] = '{0, 8'h00, 1, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[24] = '{0, 8'h00, 0, 1,  0,  0,  16'h0000, 4'd0, 0};
        vecs[25] = '{0, 8'h00, 0, 1,  0,  1,  16'h0099, 4'd1, 1};
        vecs[26] = '{0, 8'h00, 0, 1,  0,  0,  16'h0000, 4'd0, 0};

        #23;
        chk("reset valid", 64'(out_valid2), 64'd0);
        chk("reset last", 64'(out_last2), 64'd0);
        chk("reset nbytes", 64'(out_nb2), 64'd0);
        chk("reset data", 64'(out_data2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive2(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].rdy);
            chk($sformatf("row%0d ack", i), 64'(in_ack2), 64'(vecs[i].e_ack));
            chk($sformatf("row%0d valid", i), 64'(out_valid2), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d data", i), 64'(out_data2), 64'(vecs[i].e_data));
                chk($sformatf("row%0d nbytes", i), 64'(out_nb2), 64'(vecs[i].e_nb));
                chk($sformatf("row%0d last", i), 64'(out_last2), 64'(vecs[i].e_last));
            end
        end

        // BYTES=4 partial word closed by flush, then next word starts at lane 0.
        drive4(1, 8'hA1, 0); chk("w4 ack A1", 64'(in_ack4), 64'd1);
        drive4(1, 8'hA2, 0); chk("w4 ack A2", 64'(in_ack4), 64'd1);
        drive4(1, 8'hA3, 0); chk("w4 ack A3", 64'(in_ack4), 64'd1);
        drive4(0, 8'h00, 1);
        drive4(0, 8'h00, 0);
        drive4(0, 8'h00, 0);
        chk("w4 flush valid", 64'(out_valid4), 64'd1);
        chk("w4 flush data", 64'(out_data4), 64'h00A3A2A1);
        chk("w4 flush nbytes", 64'(out_nb4), 64'd3);
        chk("w4 flush last", 64'(out_last4), 64'd1);
        drive4(1, 8'hB4, 0);
        drive4(1, 8'hB5, 0);
        drive4(1, 8'hB6, 0);
        drive4(1, 8'hB7, 0); chk("w4 ack B7", 64'(in_ack4), 64'd1);
        drive4(0, 8'h00, 0);
        chk("w4 full valid", 64'(out_valid4), 64'd1);
        chk("w4 full data", 64'(out_data4), 64'hB7B6B5B4);
        chk("w4 full nbytes", 64'(out_nb4), 64'd4);
        chk("w4 full last", 64'(out_last4), 64'd0);

        // Asynchronous reset with a held word and one byte in the accumulator.
        drive2(1, 8'hC1, 0, 0);
        drive2(1, 8'hC2, 0, 0);
        drive2(1, 8'hC3, 0, 0);
        drive2(0, 8'h00, 0, 0);
        chk("pre-reset valid", 64'(out_valid2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async valid", 64'(out_valid2), 64'd0);
        chk("async data", 64'(out_data2), 64'd0);
        chk("async nbytes", 64'(out_nb2), 64'd0);
        chk("async last", 64'(out_last2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive2(0, 8'h00, 0, 1);
            chk($sformatf("post-reset idle%0d valid", i), 64'(out_valid2), 64'd0);
        end
        drive2(1, 8'hD1, 0, 1);
        drive2(1, 8'hD2, 0, 1);
        drive2(0, 8'h00, 0, 1);
        chk("post-reset word valid", 64'(out_valid2), 64'd1);
        chk("post-reset word data", 64'(out_data2), 64'hD2D1);

        // Idle timeout on a single byte.
        cfg2 = 16'd5;
        drive2(0, 8'h00, 0, 1);
        drive2(1, 8'h7E, 0, 1);
        cyc = 0;
        while (!out_valid2 && cyc < 30) begin
            drive2(0, 8'h00, 0, 1);
            cyc++;
        end
`ifdef PACKER_TIMEOUT_EN
        chk("timeout word seen", 64'(out_valid2), 64'd1);
        chk("timeout not early", 64'(cyc >= 6), 64'd1);
        chk("timeout not late", 64'(cyc <= 9), 64'd1);
        chk("timeout data", 64'(out_data2), 64'h007E);
        chk("timeout nbytes", 64'(out_nb2), 64'd1);
        chk("timeout last", 64'(out_last2), 64'd1);
`else
        chk("no timeout word", 64'(out_valid2), 64'd0);
        drive2(0, 8'h00, 1, 1);
        drive2(0, 8'h00, 0, 1);
        drive2(0, 8'h00, 0, 1);
        chk("manual flush valid", 64'(out_valid2), 64'd1);
        chk("manual flush data", 64'(out_data2), 64'h007E);
        chk("manual flush nbytes", 64'(out_nb2), 64'd1);
        chk("manual flush last", 64'(out_last2), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
